// File: rtl/dds_pkg.sv
// Shared widths and types for the DDS sine generator.
// Imported by the sine ROM and the top level.
package dds_pkg;

    localparam int PHASE_W   = 8;
    localparam int DATA_W    = 8;
    localparam int ROM_DEPTH = 256;

    typedef logic signed [DATA_W-1:0] sample_t;

    // Step used after reset, so the block free-runs with a 256-cycle period.
    localparam logic [PHASE_W-1:0] RESET_STEP = 8'd1;

endpackage

// File: rtl/dds_sine_rom.sv
// Combinational full-period sine lookup: sample = round(127*sin(2*pi*phase/256)).
// The caller registers the output.
module dds_sine_rom
    import dds_pkg::*;
(
    input  logic [$clog2(ROM_DEPTH)-1:0] phase,
    output sample_t                      sample
);

    always_comb begin
        // NOTE: give every always_comb output a value before any branch so no path can infer a latch.
        sample = '0;
        case (phase)
            8'd0:   sample = 8'sd0;    8'd1:   sample = 8'sd3;    8'd2:   sample = 8'sd6;    8'd3:   sample = 8'sd9;
            8'd4:   sample = 8'sd12;   8'd5:   sample = 8'sd16;   8'd6:   sample = 8'sd19;   8'd7:   sample = 8'sd22;
            8'd8:   sample = 8'sd25;   8'd9:   sample = 8'sd28;   8'd10:  sample = 8'sd31;   8'd11:  sample = 8'sd34;
            8'd12:  sample = 8'sd37;   8'd13:  sample = 8'sd40;   8'd14:  sample = 8'sd43;   8'd15:  sample = 8'sd46;
            8'd16:  sample = 8'sd49;   8'd17:  sample = 8'sd51;   8'd18:  sample = 8'sd54;   8'd19:  sample = 8'sd57;
            8'd20:  sample = 8'sd60;   8'd21:  sample = 8'sd63;   8'd22:  sample = 8'sd65;   8'd23:  sample = 8'sd68;
            8'd24:  sample = 8'sd71;   8'd25:  sample = 8'sd73;   8'd26:  sample = 8'sd76;   8'd27:  sample = 8'sd78;
            8'd28:  sample = 8'sd81;   8'd29:  sample = 8'sd83;   8'd30:  sample = 8'sd85;   8'd31:  sample = 8'sd88;
            8'd32:  sample = 8'sd90;   8'd33:  sample = 8'sd92;   8'd34:  sample = 8'sd94;   8'd35:  sample = 8'sd96;
            8'd36:  sample = 8'sd98;   8'd37:  sample = 8'sd100;  8'd38:  sample = 8'sd102;  8'd39:  sample = 8'sd104;
            8'd40:  sample = 8'sd106;  8'd41:  sample = 8'sd107;  8'd42:  sample = 8'sd109;  8'd43:  sample = 8'sd111;
            8'd44:  sample = 8'sd112;  8'd45:  sample = 8'sd113;  8'd46:  sample = 8'sd115;  8'd47:  sample = 8'sd116;
            8'd48:  sample = 8'sd117;  8'd49:  sample = 8'sd118;  8'd50:  sample = 8'sd120;  8'd51:  sample = 8'sd121;
            8'd52:  sample = 8'sd122;  8'd53:  sample = 8'sd122;  8'd54:  sample = 8'sd123;  8'd55:  sample = 8'sd124;
            8'd56:  sample = 8'sd125;  8'd57:  sample = 8'sd125;  8'd58:  sample = 8'sd126;  8'd59:  sample = 8'sd126;
            8'd60:  sample = 8'sd126;  8'd61:  sample = 8'sd127;  8'd62:  sample = 8'sd127;  8'd63:  sample = 8'sd127;
            8'd64:  sample = 8'sd127;  8'd65:  sample = 8'sd127;  8'd66:  sample = 8'sd127;  8'd67:  sample = 8'sd127;
            8'd68:  sample = 8'sd126;  8'd69:  sample = 8'sd126;  8'd70:  sample = 8'sd126;  8'd71:  sample = 8'sd125;
            8'd72:  sample = 8'sd125;  8'd73:  sample = 8'sd124;  8'd74:  sample = 8'sd123;  8'd75:  sample = 8'sd122;
            8'd76:  sample = 8'sd122;  8'd77:  sample = 8'sd121;  8'd78:  sample = 8'sd120;  8'd79:  sample = 8'sd118;
            8'd80:  sample = 8'sd117;  8'd81:  sample = 8'sd116;  8'd82:  sample = 8'sd115;  8'd83:  sample = 8'sd113;
            8'd84:  sample = 8'sd112;  8'd85:  sample = 8'sd111;  8'd86:  sample = 8'sd109;  8'd87:  sample = 8'sd107;
            8'd88:  sample = 8'sd106;  8'd89:  sample = 8'sd104;  8'd90:  sample = 8'sd102;  8'd91:  sample = 8'sd100;
            8'd92:  sample = 8'sd98;   8'd93:  sample = 8'sd96;   8'd94:  sample = 8'sd94;   8'd95:  sample = 8'sd92;
            8'd96:  sample = 8'sd90;   8'd97:  sample = 8'sd88;   8'd98:  sample = 8'sd85;   8'd99:  sample = 8'sd83;
            8'd100: sample = 8'sd81;   8'd101: sample = 8'sd78;   8'd102: sample = 8'sd76;   8'd103: sample = 8'sd73;
            8'd104: sample = 8'sd71;   8'd105: sample = 8'sd68;   8'd106: sample = 8'sd65;   8'd107: sample = 8'sd63;
            8'd108: sample = 8'sd60;   8'd109: sample = 8'sd57;   8'd110: sample = 8'sd54;   8'd111: sample = 8'sd51;
            8'd112: sample = 8'sd49;   8'd113: sample = 8'sd46;   8'd114: sample = 8'sd43;   8'd115: sample = 8'sd40;
            8'd116: sample = 8'sd37;   8'd117: sample = 8'sd34;   8'd118: sample = 8'sd31;   8'd119: sample = 8'sd28;
            8'd120: sample = 8'sd25;   8'd121: sample = 8'sd22;   8'd122: sample = 8'sd19;   8'd123: sample = 8'sd16;
            8'd124: sample = 8'sd12;   8'd125: sample = 8'sd9;    8'd126: sample = 8'sd6;    8'd127: sample = 8'sd3;
            // Second half is the negated first half.
            8'd128: sample = 8'sd0;    8'd129: sample = -8'sd3;   8'd130: sample = -8'sd6;   8'd131: sample = -8'sd9;
            8'd132: sample = -8'sd12;  8'd133: sample = -8'sd16;  8'd134: sample = -8'sd19;  8'd135: sample = -8'sd22;
            8'd136: sample = -8'sd25;  8'd137: sample = -8'sd28;  8'd138: sample = -8'sd31;  8'd139: sample = -8'sd34;
            8'd140: sample = -8'sd37;  8'd141: sample = -8'sd40;  8'd142: sample = -8'sd43;  8'd143: sample = -8'sd46;
            8'd144: sample = -8'sd49;  8'd145: sample = -8'sd51;  8'd146: sample = -8'sd54;  8'd147: sample = -8'sd57;
            8'd148: sample = -8'sd60;  8'd149: sample = -8'sd63;  8'd150: sample = -8'sd65;  8'd151: sample = -8'sd68;
            8'd152: sample = -8'sd71;  8'd153: sample = -8'sd73;  8'd154: sample = -8'sd76;  8'd155: sample = -8'sd78;
            8'd156: sample = -8'sd81;  8'd157: sample = -8'sd83;  8'd158: sample = -8'sd85;  8'd159: sample = -8'sd88;
            8'd160: sample = -8'sd90;  8'd161: sample = -8'sd92;  8'd162: sample = -8'sd94;  8'd163: sample = -8'sd96;
            8'd164: sample = -8'sd98;  8'd165: sample = -8'sd100; 8'd166: sample = -8'sd102; 8'd167: sample = -8'sd104;
            8'd168: sample = -8'sd106; 8'd169: sample = -8'sd107; 8'd170: sample = -8'sd109; 8'd171: sample = -8'sd111;
            8'd172: sample = -8'sd112; 8'd173: sample = -8'sd113; 8'd174: sample = -8'sd115; 8'd175: sample = -8'sd116;
            8'd176: sample = -8'sd117; 8'd177: sample = -8'sd118; 8'd178: sample = -8'sd120; 8'd179: sample = -8'sd121;
            8'd180: sample = -8'sd122; 8'd181: sample = -8'sd122; 8'd182: sample = -8'sd123; 8'd183: sample = -8'sd124;
            8'd184: sample = -8'sd125; 8'd185: sample = -8'sd125; 8'd186: sample = -8'sd126; 8'd187: sample = -8'sd126;
            8'd188: sample = -8'sd126; 8'd189: sample = -8'sd127; 8'd190: sample = -8'sd127; 8'd191: sample = -8'sd127;
            8'd192: sample = -8'sd127; 8'd193: sample = -8'sd127; 8'd194: sample = -8'sd127; 8'd195: sample = -8'sd127;
            8'd196: sample = -8'sd126; 8'd197: sample = -8'sd126; 8'd198: sample = -8'sd126; 8'd199: sample = -8'sd125;
            8'd200: sample = -8'sd125; 8'd201: sample = -8'sd124; 8'd202: sample = -8'sd123; 8'd203: sample = -8'sd122;
            8'd204: sample = -8'sd122; 8'd205: sample = -8'sd121; 8'd206: sample = -8'sd120; 8'd207: sample = -8'sd118;
            8'd208: sample = -8'sd117; 8'd209: sample = -8'sd116; 8'd210: sample = -8'sd115; 8'd211: sample = -8'sd113;
            8'd212: sample = -8'sd112; 8'd213: sample = -8'sd111; 8'd214: sample = -8'sd109; 8'd215: sample = -8'sd107;
            8'd216: sample = -8'sd106; 8'd217: sample = -8'sd104; 8'd218: sample = -8'sd102; 8'd219: sample = -8'sd100;
            8'd220: sample = -8'sd98;  8'd221: sample = -8'sd96;  8'd222: sample = -8'sd94;  8'd223: sample = -8'sd92;
            8'd224: sample = -8'sd90;  8'd225: sample = -8'sd88;  8'd226: sample = -8'sd85;  8'd227: sample = -8'sd83;
            8'd228: sample = -8'sd81;  8'd229: sample = -8'sd78;  8'd230: sample = -8'sd76;  8'd231: sample = -8'sd73;
            8'd232: sample = -8'sd71;  8'd233: sample = -8'sd68;  8'd234: sample = -8'sd65;  8'd235: sample = -8'sd63;
            8'd236: sample = -8'sd60;  8'd237: sample = -8'sd57;  8'd238: sample = -8'sd54;  8'd239: sample = -8'sd51;
            8'd240: sample = -8'sd49;  8'd241: sample = -8'sd46;  8'd242: sample = -8'sd43;  8'd243: sample = -8'sd40;
            8'd244: sample = -8'sd37;  8'd245: sample = -8'sd34;  8'd246: sample = -8'sd31;  8'd247: sample = -8'sd28;
            8'd248: sample = -8'sd25;  8'd249: sample = -8'sd22;  8'd250: sample = -8'sd19;  8'd251: sample = -8'sd16;
            8'd252: sample = -8'sd12;  8'd253: sample = -8'sd9;   8'd254: sample = -8'sd6;   8'd255: sample = -8'sd3;
            default: sample = '0;
        endcase
    end

endmodule

// File: rtl/dds_rom.sv
// Free-running DDS sine source: phase accumulator, sine lookup, registered sample
// output and a one-cycle marker on each accumulator carry (start of period).
module dds_rom
    import dds_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     SET,
    input  logic [PHASE_W-1:0]       step_in,
    output logic signed [DATA_W-1:0] value,
    output logic                     zero_address
);

    logic [PHASE_W-1:0] step_q;
    logic [PHASE_W-1:0] phase;
    logic               wrap_q;
    logic [PHASE_W:0]   sum;
    sample_t            rom_sample;

    // The carry out of this add marks a period boundary even when phase skips 0.
    assign sum = {1'b0, phase} + {1'b0, step_q};

    dds_sine_rom u_sine_rom (
        .phase  (phase),
        .sample (rom_sample)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            step_q <= RESET_STEP;
            phase  <= '0;
            wrap_q <= 1'b0;
        end else if (SET) begin
            // NOTE: non-blocking assignments make every register see pre-edge values, so ordering here is irrelevant.
            step_q <= step_in;
            phase  <= '0;
            wrap_q <= 1'b1;
        end else begin
            phase  <= sum[PHASE_W-1:0];
            wrap_q <= sum[PHASE_W];
        end
    end

    // Output stage: one cycle behind phase, keeping the marker aligned with its sample.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            value        <= '0;
            zero_address <= 1'b0;
        end else begin
            value        <= rom_sample;
            zero_address <= wrap_q;
        end
    end

endmodule

// File: tb/tb_dds_rom.sv
// Self-checking bench for dds_rom: a phase-count model with a real-valued sine
// reference is compared every cycle, plus directed checks on samples and pulse gaps.
module tb_dds_rom;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              SET;
    logic [7:0]        step_in;
    logic signed [7:0] value;
    logic              zero_address;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    dds_rom dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .SET          (SET),
        .step_in      (step_in),
        .value        (value),
        .zero_address (zero_address)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference sine from real arithmetic, rounded half away from zero.
    function automatic int sine_ref(input int k);
        real r;
        r = 127.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    // Model: acc counts total phase advanced since the last restart; a period
    // boundary is any step where acc/256 increases.
    int unsigned acc      = 0;
    int unsigned m_step   = 1;
    bit          m_pend   = 1'b0;
    int          exp_value = 0;
    bit          exp_zero  = 1'b0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc = 0; m_step = 1; m_pend = 1'b0; exp_value = 0; exp_zero = 1'b0;
        end else begin
            exp_value = sine_ref(int'(acc % 256));
            exp_zero  = m_pend;
            if (SET) begin
                m_step = step_in;
                acc    = 0;
                m_pend = 1'b1;
            end else begin
                m_pend = ((acc + m_step) / 256) != (acc / 256);
                acc    = acc + m_step;
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_value", value, exp_value);
            check("model_zero_address", zero_address, exp_zero);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic apply_set(input logic [7:0] step, input int hold);
        SET = 1'b1;
        step_in = step;
        tick(hold);
        SET = 1'b0;
    endtask

    // Cycles until the next zero_address pulse, or -1 if none within budget.
    task automatic cycles_to_pulse(input int budget, output int n);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (zero_address !== 1'b1 && k < budget);
        n = (zero_address === 1'b1) ? k : -1;
    endtask

    int n;

    initial begin
        RESET   = 1'b0;
        SET     = 1'b0;
        step_in = 8'd0;

        check("ref_k0", sine_ref(0), 0);
        check("ref_k3", sine_ref(3), 9);
        check("ref_k43", sine_ref(43), 111);
        check("ref_k64", sine_ref(64), 127);
        check("ref_k128", sine_ref(128), 0);
        check("ref_k192", sine_ref(192), -127);

        tick(3);
        chk_en = 1'b1;
        check("reset_value", value, 0);
        check("reset_zero_address", zero_address, 0);

        // Free run with step 1 after reset.
        RESET = 1'b1;
        tick(1);
        check("run_first_value", value, 0);
        check("run_first_zero", zero_address, 0);
        tick(1);
        check("run_second_value", value, 3);
        tick(63);
        check("run_peak", value, 127);
        tick(128);
        check("run_trough", value, -127);
        cycles_to_pulse(100, n);
        check("run_first_pulse", n, 64);
        check("run_pulse_value", value, 0);
        cycles_to_pulse(300, n);
        check("run_period", n, 256);

        // Step 64: 0, 127, 0, -127 repeating.
        apply_set(8'd64, 1);
        tick(1);
        check("s64_v0", value, 0);
        check("s64_z0", zero_address, 1);
        tick(1);
        check("s64_v1", value, 127);
        check("s64_z1", zero_address, 0);
        tick(1);
        check("s64_v2", value, 0);
        tick(1);
        check("s64_v3", value, -127);
        cycles_to_pulse(10, n);
        check("s64_gap_a", n, 1);
        cycles_to_pulse(10, n);
        check("s64_gap_b", n, 4);

        // SET held for three edges keeps the phase at 0 and the marker high.
        apply_set(8'd64, 3);
        check("hold_z", zero_address, 1);
        check("hold_v", value, 0);
        tick(1);
        check("hold_last_z", zero_address, 1);
        check("hold_last_v", value, 0);
        tick(1);
        check("hold_after_v", value, 127);
        check("hold_after_z", zero_address, 0);

        // Step 3: carries without phase ever hitting 0.
        apply_set(8'd3, 1);
        cycles_to_pulse(5, n);
        check("s3_set_pulse", n, 1);
        cycles_to_pulse(100, n);
        check("s3_gap1", n, 86);
        cycles_to_pulse(100, n);
        check("s3_gap2", n, 85);
        cycles_to_pulse(100, n);
        check("s3_gap3", n, 85);
        cycles_to_pulse(100, n);
        check("s3_gap4", n, 86);

        // Step 0: one pulse, then frozen.
        apply_set(8'd0, 1);
        cycles_to_pulse(5, n);
        check("s0_set_pulse", n, 1);
        check("s0_set_value", value, 0);
        cycles_to_pulse(1000, n);
        check("s0_no_pulse", n, -1);
        check("s0_value", value, 0);

        // Sweep: first carry after each restart lands ceil(256/step) cycles on.
        for (int s = 1; s <= 5; s++) begin
            apply_set(8'(s), 1);
            cycles_to_pulse(5, n);
            check("sweep_set_pulse", n, 1);
            cycles_to_pulse(300, n);
            check($sformatf("sweep_gap_step%0d", s), n, (256 + s - 1) / s);
            tick(1800 - 2 - ((n > 0) ? n : 0));
        end

        // Asynchronous reset while the sample is at its peak.
        apply_set(8'd64, 1);
        tick(2);
        check("pre_reset_peak", value, 127);
        #2 RESET = 1'b0;
        #1;
        check("async_reset_value", value, 0);
        check("async_reset_zero", zero_address, 0);
        tick(2);
        RESET = 1'b1;

        // Asynchronous reset mid-sweep at step 128 while the marker is high.
        apply_set(8'd128, 1);
        tick(4);
        cycles_to_pulse(4, n);
        check("s128_pulse", n, 1);
        #2 RESET = 1'b0;
        #1;
        check("s128_reset_zero", zero_address, 0);
        check("s128_reset_value", value, 0);
        tick(2);
        RESET = 1'b1;
        cycles_to_pulse(300, n);
        check("post_reset_first_pulse", n, 257);
        cycles_to_pulse(300, n);
        check("post_reset_period", n, 256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
